// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
package cu_pkg;

   // State codes double as the debug value on state_o.
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   // Opcode values of the supported instructions.
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   // ALU operation select.
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B operand select.
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // Next-PC source select.
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // Control word produced for each state, before any gating.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic       illegal;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/cu_out_decode.sv
// Combinational state-to-control-word table; anything not set is 0.
module cu_out_decode
   import cu_pkg::*;
(
   input  state_t state,
   output ctrl_t  cw
);

   // Moore decode: control word depends only on the current state.
   always_comb begin
      cw = '0;
      case (state)
         S_FETCH: begin
            cw.mem_read  = 1'b1;
            cw.ir_write  = 1'b1;
            cw.pc_write  = 1'b1;
            cw.alu_src_b = SRCB_FOUR;
            cw.alu_op    = ALU_ADD;
         end
         S_DECODE: begin
            cw.alu_src_b = SRCB_IMMSH;
            cw.alu_op    = ALU_ADD;
         end
         S_MEMADR: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            cw.iord     = 1'b1;
            cw.mem_read = 1'b1;
         end
         S_MEMWB: begin
            cw.mem_to_reg = 1'b1;
            cw.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            cw.iord      = 1'b1;
            cw.mem_write = 1'b1;
         end
         S_EXEC: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_REG;
            cw.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            cw.reg_dst   = 1'b1;
            cw.reg_write = 1'b1;
         end
         S_BRANCH: begin
            cw.alu_src_a     = 1'b1;
            cw.alu_op        = ALU_SUB;
            cw.pc_write_cond = 1'b1;
            cw.pc_src        = PC_ALUOUT;
         end
         S_ADDIEX: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALU_ADD;
         end
         S_ADDIWB: begin
            cw.reg_write = 1'b1;
         end
         S_JUMP: begin
            cw.pc_write = 1'b1;
            cw.pc_src   = PC_JUMP;
         end
         S_TRAP: begin
            cw.illegal = 1'b1;
         end
         default: cw = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle control unit: state register, opcode latch and next-state logic.
// Memory handshake: mem_ready=1 in a FETCH/MEMRD/MEMWR cycle means the access
// completes this cycle and the FSM advances on the next rising edge; with
// mem_ready=0 the state and its control word are held unchanged.
module multicycle_cu
   import cu_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int ALUOPW = 2,
   parameter int MEM_HS = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [OPW-1:0]    opcode,
   input  logic              mem_ready,
   output logic              pc_write,
   output logic              pc_write_cond,
   output logic              iord,
   output logic              mem_read,
   output logic              mem_write,
   output logic              ir_write,
   output logic              mem_to_reg,
   output logic              reg_dst,
   output logic              reg_write,
   output logic              alu_src_a,
   output logic              illegal,
   output logic [1:0]        alu_src_b,
   output logic [1:0]        pc_src,
   output logic [ALUOPW-1:0] alu_op,
   output logic [3:0]        state_o
);

   state_t         state;
   state_t         state_nx;
   logic [OPW-1:0] op_q;
   logic           rdy;
   logic           fetch_ok;
   ctrl_t          cw;

   // Without the handshake every memory access completes in one cycle.
   assign rdy = (MEM_HS == 0) ? 1'b1 : mem_ready;

   // State register; async reset forces FETCH immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nx;
   end

   // Opcode latch: the instruction in flight keeps the opcode seen in DECODE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 op_q <= '0;
      else if (state == S_DECODE) op_q <= opcode;
   end

   // Next-state logic; opcode only steers the transition out of DECODE.
   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:  state_nx = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if      (opcode == OPW'(OP_R))    state_nx = S_EXEC;
            else if (opcode == OPW'(OP_LW))   state_nx = S_MEMADR;
            else if (opcode == OPW'(OP_SW))   state_nx = S_MEMADR;
            else if (opcode == OPW'(OP_BEQ))  state_nx = S_BRANCH;
            else if (opcode == OPW'(OP_ADDI)) state_nx = S_ADDIEX;
            else if (opcode == OPW'(OP_J))    state_nx = S_JUMP;
            else                              state_nx = S_TRAP;
         end
         S_MEMADR: state_nx = (op_q == OPW'(OP_LW)) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_nx = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_nx = S_FETCH;
         S_MEMWR:  state_nx = rdy ? S_FETCH : S_MEMWR;
         S_EXEC:   state_nx = S_ALUWB;
         S_ALUWB:  state_nx = S_FETCH;
         S_BRANCH: state_nx = S_FETCH;
         S_ADDIEX: state_nx = S_ADDIWB;
         S_ADDIWB: state_nx = S_FETCH;
         S_JUMP:   state_nx = S_FETCH;
         S_TRAP:   state_nx = S_TRAP;
         default:  state_nx = S_FETCH;
      endcase
   end

   cu_out_decode u_dec (
      .state (state),
      .cw    (cw)
   );

   // In FETCH the IR load and PC increment happen only when the read completes.
   assign fetch_ok = (state != S_FETCH) || rdy;

   // Write strobes are forced low while reset is held so an aborted access never writes.
   assign pc_write      = rst_n & cw.pc_write & fetch_ok;
   assign ir_write      = rst_n & cw.ir_write & fetch_ok;
   assign pc_write_cond = rst_n & cw.pc_write_cond;
   assign mem_write     = rst_n & cw.mem_write;
   assign reg_write     = rst_n & cw.reg_write;

   assign iord       = cw.iord;
   assign mem_read   = cw.mem_read;
   assign mem_to_reg = cw.mem_to_reg;
   assign reg_dst    = cw.reg_dst;
   assign alu_src_a  = cw.alu_src_a;
   assign illegal    = cw.illegal;
   assign alu_src_b  = cw.alu_src_b;
   assign pc_src     = cw.pc_src;
   assign state_o    = state;

   // Zero-extend the 2-bit ALU operation to the configured width.
   always_comb begin
      alu_op      = '0;
      alu_op[1:0] = cw.alu_op;
   end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu with an expected-value queue.
module tb_multicycle_cu;

   localparam int W = 21;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
   logic [1:0] alu_src_b, pc_src, alu_op;
   logic [3:0] state_o;

   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   multicycle_cu #(.OPW(6), .ALUOPW(2), .MEM_HS(1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .illegal       (illegal),
      .alu_src_b     (alu_src_b),
      .pc_src        (pc_src),
      .alu_op        (alu_op),
      .state_o       (state_o)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Reference control word for a state, from the state table.
   function automatic logic [16:0] model(input logic [3:0] st, input logic mr, input logic in_rst);
      logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, ill;
      logic [1:0] asb, ps, aop;
      {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, ill} = '0;
      asb = 2'b00; ps = 2'b00; aop = 2'b00;
      case (st)
         4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
         4'd1:  asb = 2'b11;
         4'd2:  begin asa = 1; asb = 2'b10; end
         4'd3:  begin io = 1; mrd = 1; end
         4'd4:  begin m2r = 1; rw = 1; end
         4'd5:  begin io = 1; mwr = 1; end
         4'd6:  begin asa = 1; aop = 2'b10; end
         4'd7:  begin rd = 1; rw = 1; end
         4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
         4'd9:  begin asa = 1; asb = 2'b10; end
         4'd10: rw = 1;
         4'd11: begin pw = 1; ps = 2'b10; end
         4'd12: ill = 1;
         default: ;
      endcase
      if (in_rst) begin
         pw = 0; pwc = 0; mwr = 0; irw = 0; rw = 0;
      end
      return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, ill, asb, ps, aop};
   endfunction

   // Pop the oldest expectation and compare against the DUT.
   task automatic check(input string tag);
      logic [W-1:0] obs;
      logic [W-1:0] exp;
      obs = {state_o, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal, alu_src_b, pc_src, alu_op};
      exp = exp_q.pop_front();
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle at the falling edge, check, then advance to the next falling edge.
   task automatic cyc(input string tag, input logic [3:0] st, input logic mr, input logic [5:0] op);
      mem_ready = mr;
      opcode    = op;
      exp_q.push_back({st, model(st, mr, 1'b0)});
      #1;
      check(tag);
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [5:0] rnd_op();
      return 6'($urandom_range(0, 63));
   endfunction

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      opcode    = 6'd0;
      @(negedge clk);

      // Reset state: FETCH decode with write strobes gated
      mem_ready = 1'b1;
      exp_q.push_back({4'd0, model(4'd0, 1'b1, 1'b1)});
      #1;
      check("reset");
      rst_n = 1'b1;

      // R-type: 0,1,6,7
      cyc("r_fetch",  4'd0, 1'b1, 6'b000000);
      cyc("r_decode", 4'd1, 1'b1, 6'b000000);
      cyc("r_exec",   4'd6, 1'b1, rnd_op());
      cyc("r_aluwb",  4'd7, 1'b1, rnd_op());

      // LW with two wait cycles in MEMRD: 0,1,2,3,3,3,4
      cyc("lw_fetch",  4'd0, 1'b1, 6'b100011);
      cyc("lw_decode", 4'd1, 1'b1, 6'b100011);
      cyc("lw_memadr", 4'd2, 1'b1, rnd_op());
      cyc("lw_memrd0", 4'd3, 1'b0, rnd_op());
      cyc("lw_memrd1", 4'd3, 1'b0, rnd_op());
      cyc("lw_memrd2", 4'd3, 1'b1, rnd_op());
      cyc("lw_memwb",  4'd4, 1'b1, rnd_op());

      // SW with opcode switched to BEQ during MEMADR: must still go to MEMWR
      cyc("sw_fetch",  4'd0, 1'b1, 6'b101011);
      cyc("sw_decode", 4'd1, 1'b1, 6'b101011);
      cyc("sw_memadr", 4'd2, 1'b1, 6'b000100);
      cyc("sw_memwr",  4'd5, 1'b1, 6'b000100);

      // BEQ then J
      cyc("beq_fetch",  4'd0, 1'b1, 6'b000100);
      cyc("beq_decode", 4'd1, 1'b1, 6'b000100);
      cyc("beq_branch", 4'd8, 1'b1, rnd_op());
      cyc("j_fetch",    4'd0, 1'b1, 6'b000010);
      cyc("j_decode",   4'd1, 1'b1, 6'b000010);
      cyc("j_jump",     4'd11, 1'b1, rnd_op());

      // ADDI with one FETCH wait cycle
      cyc("addi_fetchw", 4'd0, 1'b0, 6'b001000);
      cyc("addi_fetch",  4'd0, 1'b1, 6'b001000);
      cyc("addi_decode", 4'd1, 1'b1, 6'b001000);
      cyc("addi_ex",     4'd9, 1'b1, rnd_op());
      cyc("addi_wb",     4'd10, 1'b1, rnd_op());

      // Illegal opcode: TRAP is sticky regardless of inputs
      cyc("ill_fetch",  4'd0, 1'b1, 6'b111111);
      cyc("ill_decode", 4'd1, 1'b1, 6'b111111);
      for (int i = 0; i < 10; i++)
         cyc("trap_hold", 4'd12, 1'($urandom_range(0, 1)), rnd_op());

      // Reset pulse leaves TRAP
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      exp_q.push_back({4'd0, model(4'd0, 1'b1, 1'b1)});
      #1;
      check("trap_reset");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc("post_trap_fetch", 4'd0, 1'b1, 6'b000010);
      cyc("post_trap_decode", 4'd1, 1'b1, 6'b000010);
      cyc("post_trap_jump", 4'd11, 1'b1, rnd_op());

      // Reset during a MEMWR wait: mem_write drops without a clock edge
      cyc("sw2_fetch",  4'd0, 1'b1, 6'b101011);
      cyc("sw2_decode", 4'd1, 1'b1, 6'b101011);
      cyc("sw2_memadr", 4'd2, 1'b1, rnd_op());
      mem_ready = 1'b0;
      exp_q.push_back({4'd5, model(4'd5, 1'b0, 1'b0)});
      #1;
      check("sw2_memwr_wait");
      #1;
      rst_n = 1'b0;
      exp_q.push_back({4'd0, model(4'd0, 1'b0, 1'b1)});
      #1;
      check("sw2_async_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Recovery after abort
      cyc("rec_fetch",  4'd0, 1'b1, 6'b000000);
      cyc("rec_decode", 4'd1, 1'b1, 6'b000000);
      cyc("rec_exec",   4'd6, 1'b1, rnd_op());
      cyc("rec_aluwb",  4'd7, 1'b1, rnd_op());
      cyc("rec_back",   4'd0, 1'b0, rnd_op());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
